// File: rtl/izhikevich_synapse.sv
// izhikevich_synapse: delays presynaptic spikes by DELAY apply steps, then
// integrates them into an exponentially decaying, magnitude-clamped synaptic
// current that feeds the postsynaptic core's `i` input.
//
// Step protocol: `apply` is a one-cycle strobe, with no back-pressure.
// Every cycle with apply=1 is one full integration step.
// `valid` is high for exactly one cycle, the cycle after each apply.
// In that cycle i_syn, arrived and spike_count show the result of that step.
module izhikevich_synapse #(
  parameter int N           = 16,
  parameter int Q           = 6,
  parameter int DELAY       = 2,
  parameter int DECAY_SHIFT = 3,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                apply,
  input  logic                pre_spike,
  input  logic signed [N-1:0] weight,
  input  logic        [N-1:0] g_max,
  output logic signed [N-1:0] i_syn,
  output logic                arrived,
  output logic                valid,
  output logic    [CNT_W-1:0] spike_count
);

  // Sum width: two guard bits cover g - dec + weight without overflow.
  localparam int W = N + 2;

  // Reject parameter sets the datapath cannot represent.
  if (DELAY < 0 || DELAY > 15 || Q < 0 || Q >= N) begin : g_bad_param
    $error("izhikevich_synapse: DELAY must be 0..15 and Q must be 0..N-1");
  end

  logic hit;

  if (DELAY == 0) begin : g_no_delay
    assign hit = pre_spike;
  end else if (DELAY == 1) begin : g_delay_one
    logic sr;
    // Single-stage delay line, advanced only on apply.
    always_ff @(posedge clk) begin
      if (rst) sr <= 1'b0;
      else if (apply) sr <= pre_spike;
    end
    assign hit = sr;
  end else begin : g_delay_n
    logic [DELAY-1:0] sr;
    // Multi-stage delay line, advanced only on apply; the oldest bit is the arrival.
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else if (apply) sr <= {sr[DELAY-2:0], pre_spike};
    end
    assign hit = sr[DELAY-1];
  end

  logic signed [N-1:0] dec_shift;
  logic signed [N-1:0] dec;
  logic signed [W-1:0] g_x;
  logic signed [W-1:0] dec_x;
  logic signed [W-1:0] w_x;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] gmax_x;
  logic signed [W-1:0] gmin_x;
  logic signed [N-1:0] g_next;

  // Decay term, with a one-LSB floor so a small positive residue still drains to 0.
  always_comb begin
    dec_shift = i_syn >>> DECAY_SHIFT;
    dec       = dec_shift;
    if (dec_shift == '0 && i_syn != '0) begin
      dec = i_syn[N-1] ? '1 : {{(N-1){1'b0}}, 1'b1};
    end
  end

  assign g_x    = {{2{i_syn[N-1]}}, i_syn};
  assign dec_x  = {{2{dec[N-1]}}, dec};
  assign w_x    = hit ? {{2{weight[N-1]}}, weight} : '0;
  assign sum    = g_x - dec_x + w_x;
  // g_max is a magnitude, so it is zero-extended before use.
  assign gmax_x = {2'b00, g_max};
  assign gmin_x = -gmax_x;

  // Symmetric clamp to [-g_max, +g_max], applied every step.
  always_comb begin
    g_next = sum[N-1:0];
    if (sum > gmax_x) begin
      g_next = g_max;
    end else if (sum < gmin_x) begin
      g_next = gmin_x[N-1:0];
    end
  end

  // Step register: current, pulses and saturating arrival counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_syn       <= '0;
      arrived     <= 1'b0;
      valid       <= 1'b0;
      spike_count <= '0;
    end else begin
      valid   <= apply;
      arrived <= apply & hit;
      if (apply) i_syn <= g_next;
      if (apply && hit && spike_count != '1) spike_count <= spike_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_izhikevich_synapse.sv
// Bench for izhikevich_synapse: two instances share one stimulus stream.
// dut_a: DELAY=2, CNT_W=16. dut_b: DELAY=0, CNT_W=4.
// An integer reference model pushes the expected step results into per-DUT queues.
module tb_izhikevich_synapse;
  localparam int N    = 16;
  localparam int CW_A = 16;
  localparam int CW_B = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                apply;
  logic                pre_spike;
  logic signed [N-1:0] weight;
  logic        [N-1:0] g_max;

  logic signed [N-1:0] i_syn_a, i_syn_b;
  logic                arrived_a, arrived_b, valid_a, valid_b;
  logic     [CW_A-1:0] count_a;
  logic     [CW_B-1:0] count_b;

  izhikevich_synapse #(.N(N), .Q(6), .DELAY(2), .DECAY_SHIFT(3), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .apply(apply), .pre_spike(pre_spike), .weight(weight),
    .g_max(g_max), .i_syn(i_syn_a), .arrived(arrived_a), .valid(valid_a),
    .spike_count(count_a));

  izhikevich_synapse #(.N(N), .Q(6), .DELAY(0), .DECAY_SHIFT(3), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .apply(apply), .pre_spike(pre_spike), .weight(weight),
    .g_max(g_max), .i_syn(i_syn_b), .arrived(arrived_b), .valid(valid_b),
    .spike_count(count_b));

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard state
  logic [N+CW_A:0] exp_qa[$];
  logic [N+CW_B:0] exp_qb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int   mg_a, mg_b, mc_a, mc_b;
  logic ms0, ms1;
  int   obs_a, obs_b;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One step of the integer model: floor-division decay, unit floor, clamp.
  function automatic int model_next(input int g, input int add, input int gm);
    int dec, s;
    if (g >= 0) dec = g / 8;
    else        dec = -((-g + 7) / 8);
    if (dec == 0 && g != 0) dec = (g > 0) ? 1 : -1;
    s = g - dec + add;
    if (s > gm)       return gm;
    else if (s < -gm) return -gm;
    else              return s;
  endfunction

  // Driver: one clock cycle with the given apply/pre_spike; result checked after the edge.
  task automatic step(input logic a, input logic p);
    logic hit_a;
    logic [N+CW_A:0] ea;
    logic [N+CW_B:0] eb;
    @(negedge clk);
    apply = a;
    pre_spike = p;
    if (a) begin
      hit_a = ms1;
      ms1 = ms0;
      ms0 = p;
      mg_a = model_next(mg_a, hit_a ? int'(weight) : 0, int'(g_max));
      if (hit_a && mc_a < 65535) mc_a++;
      exp_qa.push_back({16'(mg_a), hit_a, 16'(mc_a)});
      mg_b = model_next(mg_b, p ? int'(weight) : 0, int'(g_max));
      if (p && mc_b < 15) mc_b++;
      exp_qb.push_back({16'(mg_b), p, 4'(mc_b)});
    end
    @(posedge clk);
    #1;
    if (valid_a) begin
      if (exp_qa.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        ea = exp_qa.pop_front();
        check("a_step", {i_syn_a, arrived_a, count_a}, ea);
      end
    end else if (exp_qa.size() != 0) begin
      check("a_missing_valid", 0, 1);
      exp_qa.delete();
    end
    if (valid_b) begin
      if (exp_qb.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        eb = exp_qb.pop_front();
        check("b_step", {i_syn_b, arrived_b, count_b}, eb);
      end
    end else if (exp_qb.size() != 0) begin
      check("b_missing_valid", 0, 1);
      exp_qb.delete();
    end
    if (!a) begin
      check("a_idle_hold", {valid_a, arrived_a, i_syn_a}, {2'b00, 16'(mg_a)});
      check("b_idle_hold", {valid_b, arrived_b, i_syn_b}, {2'b00, 16'(mg_b)});
    end
    obs_a = int'(i_syn_a);
    obs_b = int'(i_syn_b);
  endtask

  // Reset with apply and a spike present in the same cycle: reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    apply = 1'b1;
    pre_spike = 1'b1;
    @(posedge clk);
    #1;
    check("rst_a", {i_syn_a, arrived_a, valid_a, count_a}, 0);
    check("rst_b", {i_syn_b, arrived_b, valid_b, count_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    apply = 1'b0;
    pre_spike = 1'b0;
    mg_a = 0; mg_b = 0; mc_a = 0; mc_b = 0; ms0 = 1'b0; ms1 = 1'b0;
    exp_qa.delete();
    exp_qb.delete();
  endtask

  initial begin
    rst = 1'b1; apply = 1'b0; pre_spike = 1'b0; weight = '0; g_max = 16'd640;
    mg_a = 0; mg_b = 0; mc_a = 0; mc_b = 0; ms0 = 1'b0; ms1 = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();

    // Reset priority: spikes in flight are discarded.
    weight = 16'sd320;
    step(1, 1);
    step(1, 1);
    do_reset();
    step(1, 0);
    check("rst_no_arrival_1", arrived_a, 0);
    step(1, 0);
    check("rst_no_arrival_2", arrived_a, 0);
    check("rst_count_a", count_a, 0);
    check("rst_isyn_a", obs_a, 0);

    // Delay and decay on dut_a.
    do_reset();
    weight = 16'sd320; g_max = 16'd640;
    step(1, 1); check("delay_1", obs_a, 0);
    step(1, 0); check("delay_2", obs_a, 0);
    step(1, 0); check("delay_3", obs_a, 320); check("delay_arr3", arrived_a, 1);
    step(1, 0); check("decay_4", obs_a, 280); check("decay_arr4", arrived_a, 0);
    step(1, 0); check("decay_5", obs_a, 245);
    step(1, 0); check("decay_6", obs_a, 215);

    // Saturation on dut_b, then a reduced g_max pulls g in.
    do_reset();
    weight = 16'sd320; g_max = 16'd640;
    step(1, 1); check("sat_1", obs_b, 320); check("sat_cnt_1", count_b, 1);
    step(1, 1); check("sat_2", obs_b, 600); check("sat_cnt_2", count_b, 2);
    step(1, 1); check("sat_3", obs_b, 640); check("sat_cnt_3", count_b, 3);
    step(1, 1); check("sat_4", obs_b, 640); check("sat_cnt_4", count_b, 4);
    g_max = 16'd400;
    step(1, 0); check("gmax_shrink", obs_b, 400);

    // Inhibitory weight drains exactly to zero.
    do_reset();
    weight = -16'sd64; g_max = 16'd640;
    step(1, 1); check("inh_1", obs_b, -64);
    step(1, 0); check("inh_2", obs_b, -56);
    step(1, 0); check("inh_3", obs_b, -49);
    repeat (40) step(1, 0);
    check("inh_zero", obs_b, 0);
    step(1, 0); check("inh_stays_zero", obs_b, 0);

    // Positive residue drains one LSB per step.
    do_reset();
    weight = 16'sd5;
    step(1, 1); check("res_0", obs_b, 5);
    for (int k = 4; k >= 0; k--) begin
      step(1, 0);
      check("res_step", obs_b, k);
    end

    // Gapped applies: spikes offered on apply=0 cycles are ignored.
    do_reset();
    weight = 16'sd100;
    for (int k = 0; k < 6; k++) begin
      step(1, (k % 2) == 0);
      step(0, 1);
      step(0, 1);
    end
    check("gap_count_b", count_b, 3);
    check("gap_count_a", count_a, 2);

    // Counter saturation for the 4-bit counter.
    do_reset();
    weight = '0;
    repeat (20) step(1, 1);
    check("cnt_sat_b", count_b, 15);
    check("cnt_a", count_a, 18);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      weight = 16'($signed(int'($urandom_range(600)) - 300));
      if ($urandom_range(15) == 0) g_max = 16'($urandom_range(1000));
      if ($urandom_range(60) == 0) do_reset();
      step(1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
